// File: rtl/seq_det_ctrl.sv
// Word-level sequencer for a bit-serial "101" Moore detector: shifts a word
// MSB-first into the detector, counts its detections and reports them with a done pulse.
module seq_det_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_ready,
  input  logic              i_abort,
  output logic              o_det_en,
  output logic              o_det_seq,
  input  logic              i_det_detect,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned IDX_W = $clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_TAIL,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [WORD_W-1:0] shreg, shreg_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
  logic [CNT_W-1:0]  count_nx;
  logic              ready_nx, busy_nx, done_nx, det_en_nx, det_seq_nx;

  // Saturating increment: a full counter holds its value.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      idx       <= '0;
      cnt       <= '0;
      o_count   <= '0;
      o_ready   <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_det_en  <= 1'b0;
      o_det_seq <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      o_count   <= count_nx;
      o_ready   <= ready_nx;
      o_busy    <= busy_nx;
      o_done    <= done_nx;
      o_det_en  <= det_en_nx;
      o_det_seq <= det_seq_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    idx_nx   = idx;
    cnt_nx   = cnt;
    count_nx = o_count;

    case (state)
      S_IDLE: begin
        if (i_valid && !i_abort) begin
          state_nx = S_SHIFT;
          shreg_nx = i_word;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      end
      S_SHIFT: begin
        shreg_nx = {shreg[WORD_W-2:0], 1'b0};
        idx_nx   = idx + IDX_W'(1);
        // The first cycle's detect belongs to the previous word's last bit.
        if ((idx != '0) && i_det_detect) cnt_nx = cnt_inc;
        if (idx == LAST_IDX) state_nx = S_TAIL;
      end
      S_TAIL: begin
        if (i_det_detect) cnt_nx = cnt_inc;
        count_nx = cnt_nx;
        state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (i_abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      count_nx = '0;
    end
  end

  // Moore outputs are registered from the next state.
  always_comb begin
    ready_nx   = (state_nx == S_IDLE);
    busy_nx    = (state_nx != S_IDLE);
    done_nx    = (state_nx == S_DONE);
    det_en_nx  = (state_nx == S_SHIFT);
    det_seq_nx = det_en_nx & shreg_nx[WORD_W-1];
  end

endmodule
